// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with
// memory-wait timeout, retired-instruction counter and sticky trap state.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FETCH     | imem request held until response, then load IR
// DECODE    | latch instruction class and ALU op, or trap on no class
// EXECUTE   | branches retire here; loads/stores go to MEM
// MEM       | dmem request held until response; stores retire here
// WRITEBACK | register-file write and PC update, retires
// TRAP      | all strobes off, stays here until reset
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             rtype_i,
  input  logic             itype_i,
  input  logic             load_i,
  input  logic             store_i,
  input  logic             branch_i,
  input  logic             jalr_i,
  input  logic             jal_i,
  input  logic             lui_i,
  input  logic             branch_taken_i,
  input  logic             imem_valid_i,
  input  logic             dmem_valid_i,
  output logic             imem_req_o,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic             ir_we_o,
  output logic             reg_we_o,
  output logic             pc_we_o,
  output logic [1:0]       pc_sel_o,
  output logic [2:0]       aluop_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instret_o,
  output logic             trap_o
);

  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] TO_VAL = WAIT_W'(TIMEOUT_CYCLES);
  localparam logic TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_LOAD, C_STORE, C_BRANCH, C_I, C_JALR, C_JAL, C_LUI
  } cls_t;

  state_t            r_state;
  state_t            w_state_nxt;
  cls_t              r_cls;
  cls_t              w_dec_cls;
  logic [2:0]        w_dec_aluop;
  logic              w_dec_ok;
  logic [2:0]        r_aluop;
  logic [CNT_W-1:0]  r_instret;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_inc;
  logic              w_timeout;

  assign w_wait_inc = r_wait + WAIT_W'(1);
  assign w_timeout  = TO_EN && (w_wait_inc == TO_VAL);

  // Class priority: rtype > load > store > branch > itype > jalr > jal > lui
  always_comb begin
    w_dec_cls   = C_R;
    w_dec_aluop = 3'b111;
    w_dec_ok    = 1'b1;
    if (rtype_i) begin
      w_dec_cls   = C_R;
      w_dec_aluop = 3'b000;
    end else if (load_i) begin
      w_dec_cls   = C_LOAD;
      w_dec_aluop = 3'b100;
    end else if (store_i) begin
      w_dec_cls   = C_STORE;
      w_dec_aluop = 3'b101;
    end else if (branch_i) begin
      w_dec_cls   = C_BRANCH;
      w_dec_aluop = 3'b010;
    end else if (itype_i) begin
      w_dec_cls   = C_I;
      w_dec_aluop = 3'b001;
    end else if (jalr_i) begin
      w_dec_cls   = C_JALR;
      w_dec_aluop = 3'b011;
    end else if (jal_i) begin
      w_dec_cls   = C_JAL;
      w_dec_aluop = 3'b011;
    end else if (lui_i) begin
      w_dec_cls   = C_LUI;
      w_dec_aluop = 3'b110;
    end else begin
      w_dec_ok    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!stall_i) begin
      unique case (r_state)
        S_FETCH: begin
          if (imem_valid_i)   w_state_nxt = S_DECODE;
          else if (w_timeout) w_state_nxt = S_TRAP;
        end
        S_DECODE: w_state_nxt = w_dec_ok ? S_EXEC : S_TRAP;
        S_EXEC: begin
          if (r_cls == C_LOAD || r_cls == C_STORE) w_state_nxt = S_MEM;
          else if (r_cls == C_BRANCH)              w_state_nxt = S_FETCH;
          else                                     w_state_nxt = S_WB;
        end
        S_MEM: begin
          if (dmem_valid_i)   w_state_nxt = (r_cls == C_STORE) ? S_FETCH : S_WB;
          else if (w_timeout) w_state_nxt = S_TRAP;
        end
        S_WB:    w_state_nxt = S_FETCH;
        default: w_state_nxt = S_TRAP;
      endcase
    end
  end

  // Write strobes are gated by stall; requests keep their state value.
  always_comb begin
    imem_req_o = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    ir_we_o    = 1'b0;
    reg_we_o   = 1'b0;
    pc_we_o    = 1'b0;
    pc_sel_o   = 2'd0;
    unique case (r_state)
      S_FETCH: begin
        imem_req_o = 1'b1;
        ir_we_o    = imem_valid_i & ~stall_i;
      end
      S_EXEC: begin
        if (r_cls == C_BRANCH) begin
          pc_we_o  = ~stall_i;
          pc_sel_o = branch_taken_i ? 2'd1 : 2'd0;
        end
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = (r_cls == C_STORE);
        pc_we_o    = (r_cls == C_STORE) & dmem_valid_i & ~stall_i;
      end
      S_WB: begin
        reg_we_o = ~stall_i;
        pc_we_o  = ~stall_i;
        if (r_cls == C_JAL)       pc_sel_o = 2'd1;
        else if (r_cls == C_JALR) pc_sel_o = 2'd2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cls     <= C_R;
      r_aluop   <= 3'b111;
      r_instret <= '0;
      r_wait    <= '0;
    end else begin
      if (pc_we_o) r_instret <= r_instret + CNT_W'(1);
      if (!stall_i) begin
        if (r_state == S_DECODE) begin
          r_cls   <= w_dec_cls;
          r_aluop <= w_dec_aluop;
        end
        if (r_state == S_FETCH) begin
          r_wait <= imem_valid_i ? '0 : w_wait_inc;
        end else if (r_state == S_MEM) begin
          r_wait <= dmem_valid_i ? '0 : w_wait_inc;
        end else begin
          r_wait <= '0;
        end
      end
    end
  end

  assign aluop_o   = r_aluop;
  assign state_o   = r_state;
  assign instret_o = r_instret;
  assign trap_o    = (r_state == S_TRAP);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with a short memory timeout (4 cycles).
module tb_multicycle_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni, stall_i;
  logic        rtype_i, itype_i, load_i, store_i, branch_i, jalr_i, jal_i, lui_i;
  logic        branch_taken_i, imem_valid_i, dmem_valid_i;
  logic        imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, reg_we_o, pc_we_o;
  logic [1:0]  pc_sel_o;
  logic [2:0]  aluop_o, state_o;
  logic [31:0] instret_o;
  logic        trap_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  multicycle_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i),
    .rtype_i(rtype_i), .itype_i(itype_i), .load_i(load_i), .store_i(store_i),
    .branch_i(branch_i), .jalr_i(jalr_i), .jal_i(jal_i), .lui_i(lui_i),
    .branch_taken_i(branch_taken_i), .imem_valid_i(imem_valid_i),
    .dmem_valid_i(dmem_valid_i), .imem_req_o(imem_req_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .ir_we_o(ir_we_o), .reg_we_o(reg_we_o), .pc_we_o(pc_we_o),
    .pc_sel_o(pc_sel_o), .aluop_o(aluop_o), .state_o(state_o),
    .instret_o(instret_o), .trap_o(trap_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_flags();
    rtype_i = 0; itype_i = 0; load_i = 0; store_i = 0;
    branch_i = 0; jalr_i = 0; jal_i = 0; lui_i = 0; branch_taken_i = 0;
  endtask

  // From FETCH: fetch hits immediately, advance to EXECUTE (flags left set).
  task automatic to_exec();
    imem_valid_i = 1; #1;
    tick(); imem_valid_i = 0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni = 0; stall_i = 0; imem_valid_i = 0; dmem_valid_i = 0;
    clr_flags();
    tick(); tick();
    rst_ni = 1; #1;
    chk("rst_state", state_o, 0);
    chk("rst_imem_req", imem_req_o, 1);
    chk("rst_aluop", aluop_o, 3'b111);
    chk("rst_instret", instret_o, 0);
    chk("rst_trap", trap_o, 0);

    // rtype: 0,1,2,4,0
    rtype_i = 1; imem_valid_i = 1; #1;
    chk("r_ir_we", ir_we_o, 1);
    tick(); imem_valid_i = 0; #1;
    chk("r_state_dec", state_o, 1);
    tick(); chk("r_state_exe", state_o, 2);
    chk("r_aluop", aluop_o, 3'b000);
    tick(); chk("r_state_wb", state_o, 4);
    chk("r_reg_we", reg_we_o, 1);
    chk("r_pc_we", pc_we_o, 1);
    chk("r_pc_sel", pc_sel_o, 0);
    tick(); chk("r_state_fetch", state_o, 0);
    chk("r_instret", instret_o, 1);
    clr_flags();

    // load with 3 wait cycles in MEM
    load_i = 1; to_exec();
    chk("ld_aluop", aluop_o, 3'b100);
    tick(); chk("ld_state_mem", state_o, 3);
    chk("ld_dmem_req", dmem_req_o, 1);
    chk("ld_dmem_we", dmem_we_o, 0);
    tick(); tick(); tick();
    chk("ld_still_mem", state_o, 3);
    chk("ld_dmem_req4", dmem_req_o, 1);
    dmem_valid_i = 1; #1;
    chk("ld_no_pc_we", pc_we_o, 0);
    tick(); dmem_valid_i = 0; #1;
    chk("ld_state_wb", state_o, 4);
    chk("ld_reg_we", reg_we_o, 1);
    tick(); chk("ld_instret", instret_o, 2);
    clr_flags();

    // store with 3 wait cycles, retires from MEM
    store_i = 1; to_exec();
    chk("st_aluop", aluop_o, 3'b101);
    tick(); chk("st_dmem_we", dmem_we_o, 1);
    tick(); tick(); tick();
    dmem_valid_i = 1; #1;
    chk("st_pc_we", pc_we_o, 1);
    chk("st_reg_we", reg_we_o, 0);
    chk("st_pc_sel", pc_sel_o, 0);
    tick(); dmem_valid_i = 0; #1;
    chk("st_state_fetch", state_o, 0);
    chk("st_instret", instret_o, 3);
    clr_flags();

    // taken branch retires from EXECUTE
    branch_i = 1; branch_taken_i = 1; to_exec();
    chk("br_aluop", aluop_o, 3'b010);
    chk("br_pc_we", pc_we_o, 1);
    chk("br_pc_sel", pc_sel_o, 1);
    chk("br_reg_we", reg_we_o, 0);
    tick(); chk("br_state", state_o, 0);
    chk("br_instret", instret_o, 4);
    clr_flags();

    // jalr
    jalr_i = 1; to_exec();
    chk("jalr_aluop", aluop_o, 3'b011);
    tick(); chk("jalr_pc_sel", pc_sel_o, 2);
    chk("jalr_reg_we", reg_we_o, 1);
    tick(); chk("jalr_instret", instret_o, 5);
    clr_flags();

    // rtype beats load
    rtype_i = 1; load_i = 1; to_exec();
    chk("prio_aluop", aluop_o, 3'b000);
    tick(); chk("prio_state_wb", state_o, 4);
    tick(); chk("prio_instret", instret_o, 6);
    clr_flags();

    // stall in MEM with dmem_valid pulsed (store)
    store_i = 1; to_exec(); tick();
    stall_i = 1; dmem_valid_i = 1; #1;
    chk("stall_dmem_req", dmem_req_o, 1);
    chk("stall_pc_we", pc_we_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_state", state_o, 3);
      chk("stall_pc_we_n", pc_we_o, 0);
    end
    stall_i = 0; dmem_valid_i = 0;
    tick(); chk("unstall_state", state_o, 3);
    dmem_valid_i = 1; #1;
    chk("unstall_pc_we", pc_we_o, 1);
    tick(); dmem_valid_i = 0; #1;
    chk("unstall_state_f", state_o, 0);
    chk("unstall_instret", instret_o, 7);
    clr_flags();

    // valid arriving on the timeout cycle wins
    tick(); tick(); tick();
    chk("to_edge_fetch", state_o, 0);
    rtype_i = 1; imem_valid_i = 1;
    tick(); imem_valid_i = 0; #1;
    chk("to_edge_decode", state_o, 1);
    tick(); tick(); tick();
    chk("to_edge_instret", instret_o, 8);
    clr_flags();

    // reset in the middle of MEM
    load_i = 1; to_exec(); tick();
    chk("mr_state_mem", state_o, 3);
    rst_ni = 0;
    tick(); rst_ni = 1; #1;
    chk("mr_state", state_o, 0);
    chk("mr_instret", instret_o, 0);
    chk("mr_dmem_req", dmem_req_o, 0);
    clr_flags();

    // fetch timeout: 4 FETCH cycles without valid
    tick(); tick(); tick();
    chk("tof_state3", state_o, 0);
    tick();
    chk("tof_state", state_o, 7);
    chk("tof_trap", trap_o, 1);
    chk("tof_imem_req", imem_req_o, 0);
    imem_valid_i = 1;
    tick(); chk("tof_sticky", state_o, 7);
    imem_valid_i = 0;
    rst_ni = 0; tick(); rst_ni = 1; #1;
    chk("tof_recover", trap_o, 0);

    // no class flags in DECODE -> TRAP, sticky
    imem_valid_i = 1; #1;
    tick(); imem_valid_i = 0;
    tick();
    chk("dt_state", state_o, 7);
    chk("dt_aluop", aluop_o, 3'b111);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("dt_trap_sticky", trap_o, 1);
    end
    rst_ni = 0; tick(); rst_ni = 1; #1;
    chk("dt_recover_state", state_o, 0);
    chk("dt_recover_trap", trap_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
